// File: rtl/au_pkg.sv
// Shared types and default latencies for the arithmetic-unit issue controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package au_pkg;

    localparam int AU_WIDTH      = 32;
    localparam int AU_ADD_CYCLES = 1;
    localparam int AU_MUL_CYCLES = 32;
    localparam int AU_DIV_CYCLES = 33;

    typedef enum logic [1:0] {
        AU_ADD  = 2'b00,
        AU_SUB  = 2'b01,
        AU_MULT = 2'b10,
        AU_DIV  = 2'b11
    } au_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } au_state_e;

    // Largest of three latencies; sizes the latency counter.
    function automatic int au_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/au_issue_ctrl_if.sv
// Bundles the request, AU-drive and response channels of the issue controller.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes.
// Modports: master = requester plus AU (drives req_*, rsp_ready, au results);
//           slave  = au_issue_ctrl (drives req_ready, au operands, rsp_*, busy).
interface au_issue_ctrl_if
    import au_pkg::*;
#(
    parameter int WIDTH = AU_WIDTH
);
    logic             req_valid;
    logic             req_ready;
    au_op_e           req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic [WIDTH-1:0] au_a;
    logic [WIDTH-1:0] au_b;
    au_op_e           au_op;
    logic [WIDTH-1:0] au_s;
    logic [WIDTH-1:0] au_hi;
    logic [WIDTH-1:0] au_lo;
    logic             au_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_s;
    logic [WIDTH-1:0] rsp_hi;
    logic [WIDTH-1:0] rsp_lo;
    logic             rsp_zero;
    logic             rsp_div0;
    logic             busy;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
               au_s, au_hi, au_lo, au_zero,
        input  req_ready, au_a, au_b, au_op,
               rsp_valid, rsp_s, rsp_hi, rsp_lo, rsp_zero, rsp_div0, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
               au_s, au_hi, au_lo, au_zero,
        output req_ready, au_a, au_b, au_op,
               rsp_valid, rsp_s, rsp_hi, rsp_lo, rsp_zero, rsp_div0, busy
    );
endinterface

// File: rtl/au_lat_cnt.sv
// Loadable down-counter timing how long the AU operands have been held.
// Latency: load takes effect next cycle; done is combinational (en && count==0).
// Backpressure: none; counts only while en is high and saturates at zero.
// Ports: clk, rst_n (async, active-high), load/load_val, en, done.
module au_lat_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = en && (cnt_q == '0);

endmodule

// File: rtl/au_issue_ctrl.sv
// Sequencer for the multi-cycle AU: accepts one op, holds AU operands for the op latency, returns s/hi/lo/zero.
// Latency: ADD/SUB rsp_valid at N+ADD_CYCLES+1, MULT at N+MUL_CYCLES+1, DIV at N+DIV_CYCLES+1 (accept in N).
// Backpressure: one op in flight; req_ready low in EXEC, follows rsp_ready in RESP (result handed back and a new op taken in the same cycle).
// Ports: clk, rst_n (async, active-high), io (au_issue_ctrl_if.slave: req_*, au_*, rsp_*, busy).
// Optional build macro AU_DIV0_TRAP_EN: DIV by zero answers next cycle with rsp_div0=1, hi=a, lo=all-ones,
// without touching the AU. Undefined: DIV by zero runs normally and rsp_div0 stays 0.
module au_issue_ctrl
    import au_pkg::*;
#(
    parameter int WIDTH      = AU_WIDTH,
    parameter int ADD_CYCLES = AU_ADD_CYCLES,
    parameter int MUL_CYCLES = AU_MUL_CYCLES,
    parameter int DIV_CYCLES = AU_DIV_CYCLES
) (
    input  logic           clk,
    input  logic           rst_n,
    au_issue_ctrl_if.slave io
);
    localparam int MAX_LAT = au_max3(ADD_CYCLES, MUL_CYCLES, DIV_CYCLES);
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    // Counter is loaded with LAT-1 so that done fires in the LAT-th EXEC cycle.
    function automatic logic [CNT_W-1:0] lat_m1(input au_op_e op);
        case (op)
            AU_MULT: return CNT_W'(MUL_CYCLES - 1);
            AU_DIV:  return CNT_W'(DIV_CYCLES - 1);
            default: return CNT_W'(ADD_CYCLES - 1);
        endcase
    endfunction

    au_state_e        state_q, state_d;
    logic [WIDTH-1:0] au_a_q, au_a_d;
    logic [WIDTH-1:0] au_b_q, au_b_d;
    au_op_e           au_op_q, au_op_d;
    logic [WIDTH-1:0] rsp_s_q, rsp_s_d;
    logic [WIDTH-1:0] rsp_hi_q, rsp_hi_d;
    logic [WIDTH-1:0] rsp_lo_q, rsp_lo_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_div0_q, rsp_div0_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;

    logic             req_ready_w;
    logic             start;
    logic             div0_req;
    logic             cnt_load;
    logic             cnt_done;

    // Ready is held low for as long as reset is asserted so nothing is taken
    // while the flops are being cleared.
    assign req_ready_w = !rst_n &&
                         ((state_q == IDLE) || ((state_q == RESP) && io.rsp_ready));

`ifdef AU_DIV0_TRAP_EN
    assign div0_req = (io.req_op == AU_DIV) && (io.req_b == '0);
`else
    assign div0_req = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        au_a_d     = au_a_q;
        au_b_d     = au_b_q;
        au_op_d    = au_op_q;
        rsp_s_d    = rsp_s_q;
        rsp_hi_d   = rsp_hi_q;
        rsp_lo_d   = rsp_lo_q;
        rsp_zero_d = rsp_zero_q;
        rsp_div0_d = rsp_div0_q;
        start      = 1'b0;
        cnt_load   = 1'b0;

        case (state_q)
            IDLE: start = io.req_valid;
            EXEC: begin
                if (cnt_done) begin
                    rsp_s_d    = io.au_s;
                    rsp_hi_d   = io.au_hi;
                    rsp_lo_d   = io.au_lo;
                    rsp_zero_d = io.au_zero;
                    rsp_div0_d = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (io.rsp_ready) begin
                    state_d = IDLE;
                    start   = io.req_valid;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            if (div0_req) begin
                // Trapped divide: answer directly, AU operands keep their old values.
                rsp_s_d    = '0;
                rsp_hi_d   = io.req_a;
                rsp_lo_d   = '1;
                rsp_zero_d = 1'b0;
                rsp_div0_d = 1'b1;
                state_d    = RESP;
            end else begin
                au_a_d   = io.req_a;
                au_b_d   = io.req_b;
                au_op_d  = io.req_op;
                cnt_load = 1'b1;
                state_d  = EXEC;
            end
        end

        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            au_a_q      <= '0;
            au_b_q      <= '0;
            au_op_q     <= AU_ADD;
            rsp_s_q     <= '0;
            rsp_hi_q    <= '0;
            rsp_lo_q    <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_div0_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            au_a_q      <= au_a_d;
            au_b_q      <= au_b_d;
            au_op_q     <= au_op_d;
            rsp_s_q     <= rsp_s_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_div0_q  <= rsp_div0_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    au_lat_cnt #(
        .W (CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (lat_m1(io.req_op)),
        .en       (state_q == EXEC),
        .done     (cnt_done)
    );

    assign io.req_ready = req_ready_w;
    assign io.au_a      = au_a_q;
    assign io.au_b      = au_b_q;
    assign io.au_op     = au_op_q;
    assign io.rsp_valid = rsp_valid_q;
    assign io.rsp_s     = rsp_s_q;
    assign io.rsp_hi    = rsp_hi_q;
    assign io.rsp_lo    = rsp_lo_q;
    assign io.rsp_zero  = rsp_zero_q;
    assign io.rsp_div0  = rsp_div0_q;
    assign io.busy      = busy_q;

endmodule
